color_percent_sequencer: RTL

Front-end controller for the color sensor path: selects the red, green and blue photodiode filters in turn and counts sensor output edges over a fixed gate window. It then drives the percent calculator's `per_on`/`dividend`/`divisor` request interface once per channel and collects each `percentage`/`per_done` response. It sits between the sensor pins and the percent calculator and publishes a registered RGB percentage triple to display and decision logic.

---
 rtl/color_percent_sequencer_if.sv | 15 +
 rtl/color_percent_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/color_percent_sequencer_if.sv
// Request/response link between the color sequencer and the percent calculator.
`timescale 1ns/1ps
interface color_percent_sequencer_if;
  localparam int unsigned DATA_W = 21;
  localparam int unsigned PCT_W  = 10;

  logic              per_on;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              per_done;
  logic [PCT_W-1:0]  percentage;

  modport master (output per_on, dividend, divisor, input per_done, percentage);
  modport slave  (input per_on, dividend, divisor, output per_done, percentage);
endinterface

// File: rtl/color_percent_sequencer.sv
// Steps the sensor filter through R/G/B, counts sensor edges per gate window,
// then asks the percent calculator for each channel's share and publishes the triple.
`timescale 1ns/1ps
module color_percent_sequencer #(
  parameter int unsigned GATE_CYCLES    = 1_000_000,
  parameter int unsigned SETTLE_CYCLES  = 10_000,
  parameter int unsigned COUNT_MAX      = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  input  logic                          enable_i,
  input  logic                          sensor_out_i,
  output logic                          s2_o,
  output logic                          s3_o,
  color_percent_sequencer_if.master     calc,
  output logic [9:0]                    red_pct_o,
  output logic [9:0]                    green_pct_o,
  output logic [9:0]                    blue_pct_o,
  output logic                          results_valid_o,
  output logic                          busy_o,
  output logic                          calc_error_o
);
  localparam int unsigned DATA_W = 21;
  localparam int unsigned PCT_W  = 10;
  localparam int unsigned CNT_W  = $clog2(COUNT_MAX + 1);
  localparam int unsigned SUM_W  = CNT_W + 2;
  localparam int unsigned TMR_W  = $clog2(GATE_CYCLES + SETTLE_CYCLES + TIMEOUT_CYCLES + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] GATE    = 3'd2;
  localparam logic [2:0] SUM     = 3'd3;
  localparam logic [2:0] REQ     = 3'd4;
  localparam logic [2:0] WAIT    = 3'd5;
  localparam logic [2:0] RELEASE = 3'd6;
  localparam logic [2:0] PUBLISH = 3'd7;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  logic [2:0]        state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d, g_cnt_q, g_cnt_d, b_cnt_q, b_cnt_d;
  logic [PCT_W-1:0]  r_stg_q, r_stg_d, g_stg_q, g_stg_d, b_stg_q, b_stg_d;
  logic [PCT_W-1:0]  r_pct_q, r_pct_d, g_pct_q, g_pct_d, b_pct_q, b_pct_d;
  logic [DATA_W-1:0] dividend_q, dividend_d, divisor_q, divisor_d;
  logic              per_on_q, per_on_d;
  logic              s2_q, s2_d, s3_q, s3_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              sync1_q, sync2_q, prev_q;

  logic              edge_c;
  logic [CNT_W-1:0]  cnt_sat_c;
  logic [CNT_W-1:0]  sel_cnt_c;
  logic [SUM_W-1:0]  sum_c;

  // Two-flop synchronizer plus rising-edge detector on the sensor frequency output.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sensor_out_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_c    = sync2_q & ~prev_q;
  assign cnt_sat_c = (edge_c && (cnt_q < CNT_W'(COUNT_MAX))) ? cnt_q + CNT_W'(1) : cnt_q;
  assign sum_c     = SUM_W'(r_cnt_q) + SUM_W'(g_cnt_q) + SUM_W'(b_cnt_q);

  always_comb begin
    case (ch_q)
      CH_R:    sel_cnt_c = r_cnt_q;
      CH_G:    sel_cnt_c = g_cnt_q;
      default: sel_cnt_c = b_cnt_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    timer_d    = timer_q;
    cnt_d      = cnt_q;
    r_cnt_d    = r_cnt_q;
    g_cnt_d    = g_cnt_q;
    b_cnt_d    = b_cnt_q;
    r_stg_d    = r_stg_q;
    g_stg_d    = g_stg_q;
    b_stg_d    = b_stg_q;
    r_pct_d    = r_pct_q;
    g_pct_d    = g_pct_q;
    b_pct_d    = b_pct_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    s2_d       = s2_q;
    s3_d       = s3_q;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = SETTLE;
          ch_d    = CH_R;
          timer_d = '0;
        end
      end
      SETTLE: begin
        if (timer_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          timer_d = '0;
          cnt_d   = '0;
          state_d = GATE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      GATE: begin
        cnt_d = cnt_sat_c;
        if (timer_q == TMR_W'(GATE_CYCLES - 1)) begin
          timer_d = '0;
          case (ch_q)
            CH_R:    r_cnt_d = cnt_sat_c;
            CH_G:    g_cnt_d = cnt_sat_c;
            default: b_cnt_d = cnt_sat_c;
          endcase
          if (ch_q == CH_B) begin
            state_d = SUM;
          end else begin
            ch_d    = ch_q + 2'd1;
            state_d = SETTLE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      SUM: begin
        divisor_d = DATA_W'(sum_c);
        ch_d      = CH_R;
        if (sum_c == '0) begin
          // Dark scene: nothing to divide, publish zeros without touching the calculator.
          r_stg_d = '0;
          g_stg_d = '0;
          b_stg_d = '0;
          state_d = PUBLISH;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        dividend_d = DATA_W'(sel_cnt_c);
        timer_d    = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (calc.per_done) begin
          case (ch_q)
            CH_R:    r_stg_d = calc.percentage;
            CH_G:    g_stg_d = calc.percentage;
            default: b_stg_d = calc.percentage;
          endcase
          timer_d = '0;
          state_d = RELEASE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RELEASE: begin
        if (timer_q == TMR_W'(1)) begin
          timer_d = '0;
          if (ch_q == CH_B) begin
            state_d = PUBLISH;
          end else begin
            ch_d    = ch_q + 2'd1;
            state_d = REQ;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        r_pct_d = r_stg_q;
        g_pct_d = g_stg_q;
        b_pct_d = b_stg_q;
        valid_d = 1'b1;
        err_d   = 1'b0;
        ch_d    = CH_R;
        timer_d = '0;
        state_d = enable_i ? SETTLE : IDLE;
      end
    endcase

    if (!enable_i) begin
      state_d = IDLE;
      timer_d = '0;
      cnt_d   = '0;
    end

    // Filter select follows the channel while measuring; red=00, green=11, blue=01.
    if ((state_d == SETTLE) || (state_d == GATE)) begin
      s2_d = (ch_d == CH_G);
      s3_d = (ch_d != CH_R);
    end

    per_on_d = (state_d == WAIT);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q    <= IDLE;
      ch_q       <= CH_R;
      timer_q    <= '0;
      cnt_q      <= '0;
      r_cnt_q    <= '0;
      g_cnt_q    <= '0;
      b_cnt_q    <= '0;
      r_stg_q    <= '0;
      g_stg_q    <= '0;
      b_stg_q    <= '0;
      r_pct_q    <= '0;
      g_pct_q    <= '0;
      b_pct_q    <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      per_on_q   <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      timer_q    <= timer_d;
      cnt_q      <= cnt_d;
      r_cnt_q    <= r_cnt_d;
      g_cnt_q    <= g_cnt_d;
      b_cnt_q    <= b_cnt_d;
      r_stg_q    <= r_stg_d;
      g_stg_q    <= g_stg_d;
      b_stg_q    <= b_stg_d;
      r_pct_q    <= r_pct_d;
      g_pct_q    <= g_pct_d;
      b_pct_q    <= b_pct_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      per_on_q   <= per_on_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign calc.per_on   = per_on_q;
  assign calc.dividend = dividend_q;
  assign calc.divisor  = divisor_q;
  assign s2_o            = s2_q;
  assign s3_o            = s3_q;
  assign red_pct_o       = r_pct_q;
  assign green_pct_o     = g_pct_q;
  assign blue_pct_o      = b_pct_q;
  assign results_valid_o = valid_q;
  assign busy_o          = busy_q;
  assign calc_error_o    = err_q;
endmodule
